cnn_feeder: RTL
===============

# cnn_feeder

Stimulus sequencer that drives the CNN core's input protocol from on-chip buffers: it stores one image frame and one kernel written by a host port, then streams them to the core as an `in_valid_1` burst followed by an `in_valid_2` burst, with the size select held on `number_2`/`number_4`/`number_6`. It then waits for the core's `out_valid` burst to finish before reporting completion. It is the transmitter counterpart of the CNN input interface and sits between the host/control logic and `CNN` in the chip top.

## Interface
- `DW`, 15, data word width (matches `in_data`)
- `IMG_WORDS`, 36, image words per frame
- `KER_WORDS`, 9, kernel words per frame
- `TIMEOUT`, 1024, max cycles to wait for `out_valid` activity/completion in WAIT_OUT
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  host write strobe
- `wr_sel`  in  1  0 = image buffer, 1 = kernel buffer
- `wr_data`  in  DW  host write data
- `mode`  in  2  size select: 0→number_2, 1→number_4, 2→number_6, 3 illegal; sampled with `start`
- `start`  in  1  single-cycle frame launch request
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on successful frame completion
- `err`  out  1  one-cycle pulse on rejected start, or on timeout
- `in_valid_1`, `in_valid_2`  out  1 each  CNN image/kernel valid
- `number_2`, `number_4`, `number_6`  out  1 each  one-hot size select to CNN
- `in_data`  out  DW  CNN input data
- `out_valid`  in  1  CNN result valid (monitored only)

## Operation
- Buffers: image RAM `IMG_WORDS`×DW and kernel RAM `KER_WORDS`×DW, each with a fill counter. `wr_en` writes to the address given by that buffer's fill counter, then increments the counter.
- A write to a full buffer is dropped; counter saturates; no error.
- Writes outside IDLE are ignored.
- FSM states: IDLE, SEND_IMG, GAP, SEND_KER, WAIT_OUT.
- IDLE, `start`=1:
  - Accepted if both buffers are full and `mode`≠3; latch the one-hot select and go to SEND_IMG.
  - Otherwise pulse `err` the next cycle and stay in IDLE; buffers are unchanged.
- SEND_IMG: `in_valid_1`=1, `in_data`=img[i], i = 0..IMG_WORDS-1; then go to GAP.
- GAP: exactly one cycle with `in_valid_1`=`in_valid_2`=0; then go to SEND_KER.
- SEND_KER: `in_valid_2`=1, `in_data`=ker[j], j = 0..KER_WORDS-1; then go to WAIT_OUT.
- Selected `number_*`: high from the first SEND_IMG cycle through the last SEND_KER cycle; low otherwise.
- WAIT_OUT: wait until `out_valid` has been sampled high at least once and then sampled low.
  - On that condition: pulse `done`, clear both fill counters, go to IDLE.
  - Timeout: a wait counter counts WAIT_OUT cycles. If it reaches `TIMEOUT` before the condition is met, pulse `err`, clear both fill counters, go to IDLE.
- `start` outside IDLE is ignored (no `err`).
- `in_data` is 0 whenever both valids are low.

## Timing
- All outputs are registered.
- Reset value of every output is 0; fill counters, FSM state (IDLE) and wait counter are also reset.
- Asserting `rst_n` low mid-frame drops every output to 0 immediately (asynchronously); the frame is abandoned with no `done`/`err`.
- Frame timeline, with `start` sampled in cycle T:
  - T+1 .. T+IMG_WORDS: `in_valid_1`=1
  - T+IMG_WORDS+1: GAP cycle
  - T+IMG_WORDS+2 .. T+IMG_WORDS+KER_WORDS+1: `in_valid_2`=1
  - Defaults: valid 1..36, gap 37, kernel 38..46, WAIT_OUT from 47.
- `done`/`err` are asserted in the cycle after the deciding sample.
- `busy`=1 from T+1 through the cycle that pulses `done`/`err`.
- The earliest next `start` is accepted in the cycle after that pulse, once buffers are refilled.
- A simultaneous `wr_en` and `start` in IDLE: the start check uses the pre-write fill counts, so a write that completes the buffers in the same cycle does not qualify.
- `out_valid` already high on the first WAIT_OUT cycle counts as its rising phase.

## Test plan
- Fill image with 0..35 and kernel with 100..108, `mode`=1, pulse `start` → `in_valid_1` for 36 cycles carrying 0..35 with `number_4`=1, one gap cycle, `in_valid_2` for 9 cycles carrying 100..108; `out_valid` high 4 cycles then low → `done` pulses once, `busy` returns to 0.
- `start` with only 35 image words written → `err` pulse next cycle, no valid asserted, counters unchanged. A 36th write followed by `start` → normal frame.
- Fill both buffers, `start` with `mode`=3 → `err`, stay IDLE. Write 40 image words → words 37–40 dropped; the frame streams the first 36.
- Launch a frame and hold `out_valid`=0 → `err` exactly 1024 cycles after WAIT_OUT entry, `busy` drops, fill counters read empty (next `start` → `err`).
- Drop `rst_n` at cycle 20 of SEND_IMG → all outputs 0 immediately. After release: IDLE, buffers empty, `start` → `err`.

Source files
------------

// File: rtl/cnn_feeder.sv
// cnn_feeder: holds one host-written image and kernel, streams them to CNN as in_valid_1 burst, gap, in_valid_2 burst with number_* held, then waits out out_valid; ports: host wr_en/wr_sel/wr_data, launch start/mode, status busy/done/err, CNN in_valid_1/in_valid_2/number_2/number_4/number_6/in_data, monitored out_valid
module cnn_feeder #(
  parameter int DW = 15,
  parameter int IMG_WORDS = 36,
  parameter int KER_WORDS = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    mode,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          in_valid_1,
  output logic          in_valid_2,
  output logic          number_2,
  output logic          number_4,
  output logic          number_6,
  output logic [DW-1:0] in_data,
  input  logic          out_valid
);
  localparam int IC = $clog2(IMG_WORDS + 1);
  localparam int KC = $clog2(KER_WORDS + 1);
  localparam int IA = $clog2(IMG_WORDS);
  localparam int KA = $clog2(KER_WORDS);
  localparam int XW = IA > KA ? IA : KA;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SEND_IMG, GAP, SEND_KER, WAIT_OUT} state_t;
  state_t state, state_n;
  logic [DW-1:0] img [IMG_WORDS];
  logic [DW-1:0] ker [KER_WORDS];
  logic [IC-1:0] img_cnt;
  logic [KC-1:0] ker_cnt;
  logic [XW-1:0] idx, idx_n;
  logic [TW-1:0] wcnt, wcnt_n;
  logic [2:0]    sel, sel_n;
  logic          seen, seen_n, done_n, err_n, clr, img_we, ker_we, active_n;
  assign img_we = wr_en && !wr_sel && state == IDLE && img_cnt != IC'(IMG_WORDS);
  assign ker_we = wr_en && wr_sel && state == IDLE && ker_cnt != KC'(KER_WORDS);
  assign active_n = state_n inside {SEND_IMG, GAP, SEND_KER};
  always_comb begin
    state_n = state;
    idx_n = idx;
    wcnt_n = wcnt;
    seen_n = seen;
    sel_n = sel;
    done_n = 1'b0;
    err_n = 1'b0;
    clr = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (img_cnt == IC'(IMG_WORDS) && ker_cnt == KC'(KER_WORDS) && mode != 2'd3) begin
          state_n = SEND_IMG;
          idx_n = '0;
          sel_n = 3'b1 << mode;
        end else err_n = 1'b1;
      end
      SEND_IMG: begin
        state_n = idx == XW'(IMG_WORDS - 1) ? GAP : SEND_IMG;
        idx_n = idx == XW'(IMG_WORDS - 1) ? '0 : idx + 1'b1;
      end
      GAP: state_n = SEND_KER;
      SEND_KER: begin
        state_n = idx == XW'(KER_WORDS - 1) ? WAIT_OUT : SEND_KER;
        idx_n = idx + 1'b1;
        wcnt_n = '0;
        seen_n = 1'b0;
      end
      WAIT_OUT: begin
        wcnt_n = wcnt + 1'b1;
        seen_n = seen | out_valid;
        done_n = seen && !out_valid;
        err_n = !done_n && wcnt == TW'(TIMEOUT - 1);
        clr = done_n | err_n;
        state_n = clr ? IDLE : WAIT_OUT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (img_we) img[img_cnt[IA-1:0]] <= wr_data;
    if (ker_we) ker[ker_cnt[KA-1:0]] <= wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      wcnt <= '0;
      seen <= 1'b0;
      sel <= '0;
      img_cnt <= '0;
      ker_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      in_valid_1 <= 1'b0;
      in_valid_2 <= 1'b0;
      number_2 <= 1'b0;
      number_4 <= 1'b0;
      number_6 <= 1'b0;
      in_data <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      wcnt <= wcnt_n;
      seen <= seen_n;
      sel <= sel_n;
      img_cnt <= clr ? '0 : img_we ? img_cnt + 1'b1 : img_cnt;
      ker_cnt <= clr ? '0 : ker_we ? ker_cnt + 1'b1 : ker_cnt;
      busy <= state_n != IDLE || state != IDLE;
      done <= done_n;
      err <= err_n;
      in_valid_1 <= state_n == SEND_IMG;
      in_valid_2 <= state_n == SEND_KER;
      number_2 <= active_n & sel_n[0];
      number_4 <= active_n & sel_n[1];
      number_6 <= active_n & sel_n[2];
      in_data <= state_n == SEND_IMG ? img[idx_n[IA-1:0]] : state_n == SEND_KER ? ker[idx_n[KA-1:0]] : '0;
    end
  end
endmodule
